// File: rtl/range_seq_pkg.sv
// Shared types and sizing helpers for the range-finder frame sequencer.
// Imported by the byte packer and the sequencer top.
package range_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_DRAIN,
    S_FINISH,
    S_RESULT,
    S_ABORT
  } seq_state_t;

  localparam int BYTES = 2;

  function automatic int bytes_of(input int width);
    return width / 8;
  endfunction

  function automatic int cnt_width(input int nbytes);
    return (nbytes > 1) ? $clog2(nbytes) : 1;
  endfunction

endpackage

// File: rtl/byte_packer.sv
// Packs a valid/ready byte stream MSB-first into WIDTH-bit words.
// word/word_done are valid in the cycle of the final byte transfer.
module byte_packer
  import range_seq_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic [7:0]       byte_in,
  input  logic             byte_valid,
  input  logic             ready,
  input  logic             flush,
  output logic [WIDTH-1:0] word,
  output logic             word_done
);

  localparam int NB = bytes_of(WIDTH);
  localparam int CW = cnt_width(NB);

  logic [CW-1:0] byte_cnt;
  logic          xfer;
  logic          last;

  // a flushed byte is still handshaken upstream, just never stored
  assign xfer      = byte_valid & ready & ~flush;
  assign last      = (byte_cnt == CW'(NB - 1));
  assign word_done = xfer & last;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      byte_cnt <= '0;
    end else if (flush) begin
      byte_cnt <= '0;
    end else if (xfer) begin
      byte_cnt <= last ? '0 : byte_cnt + 1'b1;
    end
  end

  if (WIDTH > 8) begin : g_wide
    logic [WIDTH-9:0] asm_q;

    assign word = {asm_q, byte_in};

    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        asm_q <= '0;
      end else if (flush) begin
        asm_q <= '0;
      end else if (xfer) begin
        asm_q <= word[WIDTH-9:0];
      end
    end
  end else begin : g_narrow
    assign word = byte_in;
  end

endmodule

// File: rtl/range_frame_sequencer.sv
// Feeds one go/finish framed run of packed samples to the range finder
// and strobes range_valid when its result can be captured.
module range_frame_sequencer
  import range_seq_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int LEN_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic [LEN_WIDTH-1:0] frame_len,
  input  logic                 abort,
  input  logic [7:0]           byte_in,
  input  logic                 byte_valid,
  output logic                 byte_ready,
  output logic [WIDTH-1:0]     data_out,
  output logic                 go,
  output logic                 finish,
  output logic                 busy,
  output logic                 range_valid,
  output logic                 frame_error
);

  seq_state_t           state_q;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] word_cnt;
  logic [WIDTH-1:0]     word;
  logic                 word_done;
  logic                 abort_take;
  logic                 flush;

  assign byte_ready = (state_q == S_COLLECT);
  assign busy       = (state_q != S_IDLE);
  assign abort_take = abort &
                      ((state_q == S_COLLECT) |
                       (state_q == S_DRAIN));
  assign flush      = abort_take | (state_q == S_IDLE);

  byte_packer #(
    .WIDTH(WIDTH)
  ) u_packer (
    .clock     (clock),
    .reset_n   (reset_n),
    .byte_in   (byte_in),
    .byte_valid(byte_valid),
    .ready     (byte_ready),
    .flush     (flush),
    .word      (word),
    .word_done (word_done)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      word_cnt    <= '0;
      data_out    <= '0;
      go          <= 1'b0;
      finish      <= 1'b0;
      range_valid <= 1'b0;
      frame_error <= 1'b0;
    end else begin
      go          <= 1'b0;
      finish      <= 1'b0;
      range_valid <= 1'b0;
      frame_error <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            if (frame_len != '0) begin
              len_q    <= frame_len;
              word_cnt <= '0;
              state_q  <= S_COLLECT;
            end else begin
              frame_error <= 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (abort) begin
            // only close the frame if the range finder saw go
            finish  <= (word_cnt != '0);
            state_q <= S_ABORT;
          end else if (word_done) begin
            data_out <= word;
            word_cnt <= word_cnt + 1'b1;
            go       <= (word_cnt == '0);
            if (word_cnt + 1'b1 == len_q) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          finish  <= 1'b1;
          state_q <= abort ? S_ABORT : S_FINISH;
        end
        S_FINISH: begin
          range_valid <= 1'b1;
          state_q     <= S_RESULT;
        end
        S_RESULT: state_q <= S_IDLE;
        S_ABORT:  state_q <= S_IDLE;
        default:  state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_range_frame_sequencer.sv
// Self-checking bench: vector table, directed corner cases and random
// traffic against a byte/word counting reference model.
module tb_range_frame_sequencer;

  localparam int W  = 16;
  localparam int LW = 8;
  localparam int NB = W / 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [LW-1:0] frame_len = '0;
  logic          abort = 1'b0;
  logic [7:0]    byte_in = '0;
  logic          byte_valid = 1'b0;
  logic          byte_ready;
  logic [W-1:0]  data_out;
  logic          go;
  logic          finish;
  logic          busy;
  logic          range_valid;
  logic          frame_error;

  range_frame_sequencer #(.WIDTH(W), .LEN_WIDTH(LW)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .start      (start),
    .frame_len  (frame_len),
    .abort      (abort),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .data_out   (data_out),
    .go         (go),
    .finish     (finish),
    .busy       (busy),
    .range_valid(range_valid),
    .frame_error(frame_error)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  // reference model: frame progress as byte counts and a post-frame tail
  bit           m_active, m_ab;
  int           m_len, m_taken, m_tail;
  logic [63:0]  acc;
  logic [W-1:0] words[$];
  logic [W-1:0] e_data, exp_rng;
  bit           e_go, e_fin, e_rv, e_ferr;

  // observer acting as the attached min/max range finder
  bit           o_on;
  logic [W-1:0] o_mn, o_mx;

  function automatic logic [W-1:0] span();
    logic [W-1:0] mn, mx;
    mn = words[0];
    mx = words[0];
    foreach (words[i]) begin
      if (words[i] < mn) mn = words[i];
      if (words[i] > mx) mx = words[i];
    end
    return mx - mn;
  endfunction

  task automatic model_reset();
    m_active = 0; m_ab = 0; m_len = 0;
    m_taken = 0; m_tail = 0; acc = '0;
    words.delete();
    e_data = '0; exp_rng = '0;
    e_go = 0; e_fin = 0; e_rv = 0; e_ferr = 0;
    o_on = 0; o_mn = '0; o_mx = '0;
  endtask

  task automatic model_edge();
    e_go = 0; e_fin = 0; e_rv = 0; e_ferr = 0;
    if (!m_active) begin
      if (start) begin
        if (frame_len != 0) begin
          m_active = 1; m_len = int'(frame_len);
          m_taken = 0; m_tail = 0; m_ab = 0;
          acc = '0; words.delete();
        end else begin
          e_ferr = 1;
        end
      end
    end else if (m_ab) begin
      m_active = 0; m_ab = 0;
    end else if (m_tail > 0) begin
      if (m_tail == 1 && abort) begin
        m_ab = 1; e_fin = 1; m_tail = 0;
      end else if (m_tail == 3) begin
        m_active = 0; m_tail = 0;
      end else begin
        m_tail++;
        e_fin = (m_tail == 2);
        e_rv  = (m_tail == 3);
      end
    end else if (abort) begin
      m_ab = 1;
      e_fin = (m_taken >= NB);
    end else if (byte_valid) begin
      acc = {acc[55:0], byte_in};
      m_taken++;
      if (m_taken % NB == 0) begin
        e_data = acc[W-1:0];
        words.push_back(acc[W-1:0]);
        if (m_taken == NB) e_go = 1;
        if (m_taken == m_len * NB) begin
          m_tail = 1;
          exp_rng = span();
        end
      end
    end
  endtask

  task automatic observe();
    if (go) begin
      o_on = 1; o_mn = data_out; o_mx = data_out;
    end else if (o_on) begin
      if (data_out < o_mn) o_mn = data_out;
      if (data_out > o_mx) o_mx = data_out;
    end
    if (finish) o_on = 0;
    if (e_rv) chk("range", o_mx - o_mn, exp_rng);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    chk("go", go, e_go);
    chk("finish", finish, e_fin);
    chk("range_valid", range_valid, e_rv);
    chk("frame_error", frame_error, e_ferr);
    chk("busy", busy, m_active);
    chk("byte_ready", byte_ready,
        m_active && !m_ab && m_tail == 0);
    chk("data_out", data_out, e_data);
    chk("go_finish_overlap", go & finish, 0);
    observe();
  endtask

  task automatic drv(bit s, int l, bit a, bit v, logic [7:0] b);
    start = s; frame_len = LW'(l); abort = a;
    byte_valid = v; byte_in = b;
    step();
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drv(0, 0, 0, 0, 8'h00);
  endtask

  task automatic send(int l, logic [7:0] b[$]);
    drv(1, l, 0, 0, 8'h00);
    foreach (b[i]) drv(0, 0, 0, 1, b[i]);
  endtask

  task automatic all_zero(string tag);
    chk({tag, "_go"}, go, 0);
    chk({tag, "_finish"}, finish, 0);
    chk({tag, "_rv"}, range_valid, 0);
    chk({tag, "_ferr"}, frame_error, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_ready"}, byte_ready, 0);
    chk({tag, "_data"}, data_out, 0);
  endtask

  typedef struct {
    bit           s;
    int           l;
    bit           v;
    logic [7:0]   b;
    bit           go, fin, rv, ferr, busy, rdy;
    logic [W-1:0] d;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1, 3, 0, 8'h00, 0, 0, 0, 0, 1, 1, 16'h0000};
    tbl[1]  = '{0, 0, 1, 8'h00, 0, 0, 0, 0, 1, 1, 16'h0000};
    tbl[2]  = '{0, 0, 1, 8'h10, 1, 0, 0, 0, 1, 1, 16'h0010};
    tbl[3]  = '{0, 0, 1, 8'h00, 0, 0, 0, 0, 1, 1, 16'h0010};
    tbl[4]  = '{0, 0, 1, 8'h05, 0, 0, 0, 0, 1, 1, 16'h0005};
    tbl[5]  = '{0, 0, 1, 8'h00, 0, 0, 0, 0, 1, 1, 16'h0005};
    tbl[6]  = '{0, 0, 1, 8'h30, 0, 0, 0, 0, 1, 0, 16'h0030};
    tbl[7]  = '{0, 0, 0, 8'h00, 0, 1, 0, 0, 1, 0, 16'h0030};
    tbl[8]  = '{0, 0, 0, 8'h00, 0, 0, 1, 0, 1, 0, 16'h0030};
    tbl[9]  = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0030};
    tbl[10] = '{1, 0, 0, 8'h00, 0, 0, 0, 1, 0, 0, 16'h0030};
    tbl[11] = '{0, 0, 0, 8'h00, 0, 0, 0, 0, 0, 0, 16'h0030};

    model_reset();
    #12;
    all_zero("reset");
    #1 reset_n = 1'b1;

    foreach (tbl[i]) begin
      start = tbl[i].s; frame_len = LW'(tbl[i].l);
      abort = 0; byte_valid = tbl[i].v; byte_in = tbl[i].b;
      @(posedge clock);
      model_edge();
      #1;
      chk($sformatf("t%0d_go", i), go, tbl[i].go);
      chk($sformatf("t%0d_fin", i), finish, tbl[i].fin);
      chk($sformatf("t%0d_rv", i), range_valid, tbl[i].rv);
      chk($sformatf("t%0d_ferr", i), frame_error, tbl[i].ferr);
      chk($sformatf("t%0d_busy", i), busy, tbl[i].busy);
      chk($sformatf("t%0d_rdy", i), byte_ready, tbl[i].rdy);
      chk($sformatf("t%0d_data", i), data_out, tbl[i].d);
      observe();
    end

    // single sample: go and finish separated by the drain cycle
    send(1, '{8'hAB, 8'hCD});
    idle(4);

    // stalled input holds the first sample
    send(2, '{8'h12, 8'h34});
    idle(5);
    drv(0, 0, 0, 1, 8'h00);
    drv(0, 0, 0, 1, 8'h01);
    idle(4);

    // abort after two of four words
    send(4, '{8'h01, 8'h02, 8'h03, 8'h04});
    drv(0, 0, 1, 0, 8'h00);
    idle(3);

    // abort after one byte of the first word
    send(2, '{8'h55});
    drv(0, 0, 1, 0, 8'h00);
    idle(3);

    // reset mid-frame, no clock edge needed
    send(2, '{8'h77, 8'h88, 8'h99});
    start = 0; abort = 0; byte_valid = 0;
    #2 reset_n = 1'b0;
    #1 all_zero("midrst");
    model_reset();
    #3 reset_n = 1'b1;
    send(1, '{8'h0F, 8'hF0});
    idle(4);

    for (int i = 0; i < 400; i++) begin
      drv(($urandom_range(0, 7) == 0),
          int'($urandom_range(0, 4)),
          ($urandom_range(0, 24) == 0),
          ($urandom_range(0, 9) < 7),
          8'($urandom));
    end
    idle(6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
